// File: rtl/jericalla_sequencer.sv
// jericalla_sequencer
//   Instruction issuer for the Jericalla datapath. Holds a loadable program
//   memory, a program counter and an FSM. Each ordinary word is issued over
//   a valid/ready handshake and the datapath's result/zf are captured one
//   cycle later. HALT (op F) and skip-if-zero (op E) run locally and are
//   never presented to the datapath.
//
//   Optional feature: define JERICALLA_SEQ_PERF_EN to add issued_count, a
//   saturating count of handshakes that is cleared by an accepted start.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start             one-cycle pulse; runs the program from address 0 (IDLE/HALT only)
//   load_en/addr/data program memory write port (IDLE/HALT only)
//   instruction       17-bit word to the datapath: [16] en, [15:12] op,
//                     [11:8] dir1, [7:4] dir2, [3:0] dirW
//   instr_valid/ready issue handshake
//   result_in, zf_in  datapath result and zero flag
//   last_result/zf    values captured for the last issued instruction
//   pc                program counter
//   busy              high in FETCH, ISSUE and CAPTURE
//   halted            high in HALT
//   issued_count      (JERICALLA_SEQ_PERF_EN only) handshake count
module jericalla_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [16:0]       load_data,
   output logic [16:0]       instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic [31:0]       result_in,
   input  logic              zf_in,
   output logic [31:0]       last_result,
   output logic              last_zf,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
`ifdef JERICALLA_SEQ_PERF_EN
   ,
   output logic [15:0]       issued_count
`endif
);

   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_SKZ  = 4'hE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_CAPTURE,
      S_HALT
   } state_t;

   state_t      state;
   logic [16:0] mem [DEPTH];
   logic [16:0] fetch_word;
   logic        ctl_state;

   assign fetch_word = mem[pc];
   assign ctl_state  = (state == S_IDLE) || (state == S_HALT);

   // Memory is deliberately not reset; a program survives rst.
   // A write coinciding with start lands on the same edge, so the following
   // FETCH already sees the new word.
   always_ff @(posedge clk) begin
      if (ctl_state && load_en)
         mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         instruction <= '0;
         instr_valid <= 1'b0;
         last_result <= '0;
         last_zf     <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc     <= '0;
                  state  <= S_FETCH;
                  busy   <= 1'b1;
                  halted <= 1'b0;
               end
            end
            S_FETCH: begin
               instruction <= fetch_word;
               case (fetch_word[15:12])
                  OP_HALT: begin
                     // pc is left pointing at the HALT word
                     state  <= S_HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end
                  OP_SKZ:
                     // stays in FETCH; pc wraps naturally modulo DEPTH
                     pc <= pc + (last_zf ? ADDR_W'(2) : ADDR_W'(1));
                  default: begin
                     state       <= S_ISSUE;
                     instr_valid <= 1'b1;
                  end
               endcase
            end
            S_ISSUE: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               last_result <= result_in;
               last_zf     <= zf_in;
               pc          <= pc + ADDR_W'(1);
               state       <= S_FETCH;
            end
            default: begin
               state       <= S_IDLE;
               instr_valid <= 1'b0;
               busy        <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

`ifdef JERICALLA_SEQ_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         issued_count <= '0;
      else if (ctl_state && start)
         issued_count <= '0;
      else if (state == S_ISSUE && instr_ready && issued_count != 16'hFFFF)
         issued_count <= issued_count + 16'd1;
   end
`endif

endmodule
